mac_pipe_arbiter: RTL and testbench

MAC_PIPE_ARBITER -- requirements
Module: mac_pipe_arbiter

---
 rtl/mac_pipe_arbiter.sv | 95 +++++++++
 tb/tb_mac_pipe_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_pipe_arbiter.sv
// Two-requester round-robin front end feeding a 3-stage signed ((x*a)+b)*c pipeline.
// Latency 3 enabled edges, one op per enabled cycle; en=0 freezes everything and drops both readies.
module mac_pipe_arbiter #(
  parameter int WLx = 8,
  parameter int WLa = 3,
  parameter int WLb = 4,
  parameter int WLc = 5,
  localparam int WLregm = WLx + WLa,
  localparam int WLrega = ((WLregm > WLb) ? WLregm : WLb) + 1,
  localparam int WLout  = WLrega + WLc,
  localparam int WLop   = WLx + WLa + WLb + WLc
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    en,
  input  logic                    req0_valid,
  input  logic                    req1_valid,
  input  logic [WLop-1:0]         req0_op,
  input  logic [WLop-1:0]         req1_op,
  output logic                    req0_ready,
  output logic                    req1_ready,
  output logic                    res0_valid,
  output logic                    res1_valid,
  output logic signed [WLout-1:0] res_data,
  output logic                    busy
);

  logic                     last_grant;
  logic                     take;
  logic [WLop-1:0]          op_sel;
  logic signed [WLx-1:0]    xs;
  logic signed [WLa-1:0]    as;
  logic signed [WLb-1:0]    bs;
  logic signed [WLc-1:0]    cs;

  logic                     v1, t1, v2, t2;
  logic signed [WLregm-1:0] regm;
  logic signed [WLb-1:0]    b1;
  logic signed [WLc-1:0]    c1, c2;
  logic signed [WLrega-1:0] rega;

  // last_grant resets to 1 so requester 0 wins the first contested cycle
  assign req0_ready = en & ~RST & req0_valid & (~req1_valid | last_grant);
  assign req1_ready = en & ~RST & req1_valid & (~req0_valid | ~last_grant);
  assign take       = req0_ready | req1_ready;
  assign op_sel     = req1_ready ? req1_op : req0_op;

  assign xs = op_sel[WLop-1 -: WLx];
  assign as = op_sel[WLb+WLc +: WLa];
  assign bs = op_sel[WLc +: WLb];
  assign cs = op_sel[0 +: WLc];

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= 1'b1;
      v1         <= 1'b0;
      t1         <= 1'b0;
      v2         <= 1'b0;
      t2         <= 1'b0;
      regm       <= '0;
      b1         <= '0;
      c1         <= '0;
      rega       <= '0;
      c2         <= '0;
      res_data   <= '0;
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
      busy       <= 1'b0;
    end else if (en) begin
      v1 <= take;
      t1 <= req1_ready;
      if (take) begin
        regm       <= WLregm'(xs) * WLregm'(as);
        b1         <= bs;
        c1         <= cs;
        last_grant <= req1_ready;
      end
      v2 <= v1;
      t2 <= t1;
      if (v1) begin
        rega <= WLrega'(regm) + WLrega'(b1);
        c2   <= c1;
      end
      // res_data only moves on a real result so it holds across bubbles
      res0_valid <= v2 & ~t2;
      res1_valid <= v2 & t2;
      if (v2) res_data <= WLout'(rega) * WLout'(c2);
      busy <= take | v1 | v2;
    end else begin
      res0_valid <= 1'b0;
      res1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mac_pipe_arbiter.sv
// Scoreboard bench for mac_pipe_arbiter: expected results queued at transfer, checked on strobe.
module tb_mac_pipe_arbiter;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic               en = 1'b0;
  logic               req0_valid = 1'b0, req1_valid = 1'b0;
  logic [19:0]        req0_op = '0, req1_op = '0;
  logic               req0_ready, req1_ready, res0_valid, res1_valid, busy;
  logic signed [19:0] res_data;

  mac_pipe_arbiter dut (
    .CLK(CLK), .RST(RST), .en(en),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res_data(res_data), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int tag;
    int data;
    int due;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_edges = 0;
  int   last_due = -10;
  int   exp_data = 0;
  bit   last_edge_en = 1'b0;
  bit   lg = 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] mkop(input int x, input int a, input int b, input int c);
    logic [7:0] xv;
    logic [2:0] av;
    logic [3:0] bv;
    logic [4:0] cv;
    xv = x[7:0];
    av = a[2:0];
    bv = b[3:0];
    cv = c[4:0];
    return {xv, av, bv, cv};
  endfunction

  function automatic int model(input logic [19:0] op);
    logic signed [7:0] x;
    logic signed [2:0] a;
    logic signed [3:0] b;
    logic signed [4:0] c;
    x = op[19:12];
    a = op[11:9];
    b = op[8:5];
    c = op[4:0];
    return ((int'(x) * int'(a)) + int'(b)) * int'(c);
  endfunction

  // One clock: check at negedge, update the model at posedge, return #1 later.
  task automatic step();
    int   exp_rdy;
    int   exp_v;
    int   exp_busy;
    exp_t it;
    @(negedge CLK);
    exp_rdy = 0;
    if (en && !RST) begin
      if (req0_valid && req1_valid) exp_rdy = lg ? 1 : 2;
      else exp_rdy = {30'b0, req1_valid, req0_valid};
    end
    chk("ready", int'({req1_ready, req0_ready}), exp_rdy);
    exp_busy = (q.size() > 0 || last_due == en_edges) ? 1 : 0;
    chk("busy", int'(busy), exp_busy);
    exp_v = 0;
    if (last_edge_en && q.size() > 0 && q[0].due == en_edges) begin
      it       = q.pop_front();
      exp_v    = (it.tag == 1) ? 2 : 1;
      exp_data = it.data;
      last_due = en_edges;
    end
    chk("res_valid", int'({res1_valid, res0_valid}), exp_v);
    chk("res_data", int'(res_data), exp_data);
    @(posedge CLK);
    if (RST) begin
      q.delete();
      lg           = 1'b1;
      last_edge_en = 1'b0;
      exp_data     = 0;
      last_due     = -10;
    end else if (en) begin
      en_edges++;
      last_edge_en = 1'b1;
      if (exp_rdy == 1) begin
        q.push_back('{tag: 0, data: model(req0_op), due: en_edges + 2});
        lg = 1'b0;
      end else if (exp_rdy == 2) begin
        q.push_back('{tag: 1, data: model(req1_op), due: en_edges + 2});
        lg = 1'b1;
      end
    end else begin
      last_edge_en = 1'b0;
    end
    #1;
  endtask

  task automatic idle(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    RST = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    en = 1'b1;
    step();
    step();
    RST = 1'b0;
    idle(1);

    // single op on requester 0: expect 52
    req0_op = mkop(5, 3, -2, 4);
    req0_valid = 1'b1;
    step();
    idle(4);
    chk("single_val", model(mkop(5, 3, -2, 4)), 52);

    // sign extremes on requester 1: expect -8304
    req1_op = mkop(-128, -4, 7, -16);
    req1_valid = 1'b1;
    step();
    idle(4);
    chk("extreme_val", model(mkop(-128, -4, 7, -16)), -8304);

    // contention straight after reset: 0,1,0,1,0,1
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req0_op = mkop(i + 1, 2, -i, 3);
      req1_op = mkop(-10 * i, -3, 5, -7 + i);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      step();
    end
    idle(4);

    // stall: op accepted, then en low for 4 edges
    req0_op = mkop(-77, 3, -8, 15);
    req0_valid = 1'b1;
    step();
    en = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    en = 1'b1;
    idle(4);

    // reset with three ops in flight, then contested grant must go to 0
    for (int i = 0; i < 3; i++) begin
      req0_op = mkop(20 + i, 1, 1, 1);
      req1_op = mkop(-20 - i, 1, 1, 1);
      req0_valid = i[0];
      req1_valid = ~i[0];
      step();
    end
    do_reset();
    req0_op = mkop(9, -1, 0, 2);
    req1_op = mkop(9, 1, 0, 2);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    idle(4);

    // random traffic with random stalls
    for (int i = 0; i < 60; i++) begin
      req0_op    = 20'($urandom);
      req1_op    = 20'($urandom);
      req0_valid = 1'($urandom_range(0, 1));
      req1_valid = 1'($urandom_range(0, 1));
      en         = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;
    idle(5);
    chk("drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
